hub75_scan_ctrl: RTL

Scan sequencer for the HUB75 panel. It walks row-pair, bitplane and column, and issues framebuffer read addresses. It shifts one bitplane of the top and bottom half-rows into the panel, latches it, then unblanks for a binary-weighted time (BCM). It sits between the framebuffer read port (1-cycle latency) and the HUB75 pins.

---
 rtl/hub75_pkg.sv | 20 ++
 rtl/hub75_bcm_timer.sv | 40 ++++
 rtl/hub75_scan_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: definitions shared by the HUB75 panel blocks
// (hub75_scan_ctrl, hub75_bcm_timer, hub75_framebuf, hub75_display).
//   state_e       scan sequencer states
//   phase_last_c  last phase of the four-cycle column shift
// Geometry-dependent widths (address, row select, pixel) depend on each
// module's own parameters, so every module derives them locally.
package hub75_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } state_e;

    // Columns shift in four phases: read top, read bottom, drive data, clock high.
    localparam logic [1:0] phase_last_c = 2'd3;

endpackage

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: binary-coded-modulation display timer.
// Loads oe_base_p << plane, counts down while the panel is lit, and flags
// the final display cycle.
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   load   in   load the count for `plane` (LATCH cycle)
//   run    in   count down (DISPLAY cycles)
//   plane  in   bitplane index being displayed
//   done   out  high on the last display cycle of the plane
module hub75_bcm_timer #(
    parameter  int oe_base_p = 4,
    parameter  int bpp_p     = 8,
    localparam int plane_w   = $clog2(bpp_p),
    localparam int cnt_w     = $clog2(oe_base_p << bpp_p) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               run,
    input  logic [plane_w-1:0] plane,
    output logic               done
);

    logic [cnt_w-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= cnt_w'(oe_base_p) << plane;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - cnt_w'(1);
        end
    end

    // The first display cycle sees the full count, so the plane is lit for
    // exactly oe_base_p << plane cycles when the exit happens at count 1.
    assign done = (cnt_q == cnt_w'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: HUB75 scan sequencer.
// Walks row-pair (outer), bitplane (inner) and column; reads the top and
// bottom pixel of each column from the framebuffer, shifts one bitplane into
// the panel, latches it and lights it for a binary-weighted time.
//   clk, rst_n          clock, asynchronous active-low reset
//   i_enable            run scanning; sampled only when a plane finishes
//   o_rd_addr, o_rd_en  framebuffer read port (data returns one cycle later)
//   i_rd_data           pixel {R,G,B}, bpp_p bits per channel
//   O_CLK, STB, OE      panel shift clock, latch (high), output enable (low)
//   o_row               row-pair select
//   R1 G1 B1 / R2 G2 B2 top / bottom half colour bits
//   o_frame_done        one-cycle pulse after the last plane of the last row
// Every output is a flop; output flops are loaded from next-state values so
// they line up with the state they describe.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter  int hpixel_p     = 64,
    parameter  int vpixel_p     = 64,
    parameter  int bpp_p        = 8,
    parameter  int oe_base_p    = 4,
    localparam int addr_width_p = $clog2(hpixel_p * vpixel_p),
    localparam int row_width_p  = $clog2(vpixel_p / 2)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    output logic [addr_width_p-1:0] o_rd_addr,
    output logic                    o_rd_en,
    input  logic [3*bpp_p-1:0]      i_rd_data,
    output logic                    O_CLK,
    output logic                    STB,
    output logic                    OE,
    output logic [row_width_p-1:0]  o_row,
    output logic                    R1,
    output logic                    G1,
    output logic                    B1,
    output logic                    R2,
    output logic                    G2,
    output logic                    B2,
    output logic                    o_frame_done
);

    localparam int col_w   = $clog2(hpixel_p);
    localparam int plane_w = $clog2(bpp_p);

    localparam logic [col_w-1:0]        col_last   = col_w'(hpixel_p - 1);
    localparam logic [plane_w-1:0]      plane_last = plane_w'(bpp_p - 1);
    localparam logic [row_width_p-1:0]  row_last   = row_width_p'(vpixel_p / 2 - 1);
    localparam logic [addr_width_p-1:0] hpix_a     = addr_width_p'(hpixel_p);
    localparam logic [addr_width_p-1:0] half_a     = addr_width_p'(vpixel_p / 2);

    typedef struct packed {
        logic [bpp_p-1:0] r;
        logic [bpp_p-1:0] g;
        logic [bpp_p-1:0] b;
    } pixel_t;

    state_e                  state_q, state_d;
    logic [1:0]              phase_q, phase_d;
    logic [col_w-1:0]        col_q, col_d;
    logic [plane_w-1:0]      plane_q, plane_d;
    logic [row_width_p-1:0]  row_q, row_d;
    logic                    frame_end;
    logic                    bcm_done;
    logic                    rd_en_d;
    logic [addr_width_p-1:0] row_a, addr_d;
    pixel_t                  top_p0;
    pixel_t                  bot_p1;

    hub75_bcm_timer #(
        .oe_base_p (oe_base_p),
        .bpp_p     (bpp_p)
    ) u_bcm_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state_q == LATCH),
        .run   (state_q == DISPLAY),
        .plane (plane_q),
        .done  (bcm_done)
    );

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        col_d     = col_q;
        plane_d   = plane_q;
        row_d     = row_q;
        frame_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d = SHIFT;
                    phase_d = 2'd0;
                    col_d   = '0;
                end
            end
            SHIFT: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == phase_last_c) begin
                    if (col_q == col_last) begin
                        col_d   = '0;
                        state_d = BLANK;
                    end else begin
                        col_d = col_q + col_w'(1);
                    end
                end
            end
            BLANK:   state_d = LATCH;
            LATCH:   state_d = DISPLAY;
            DISPLAY: begin
                // Counters advance even when stopping, so a later enable
                // resumes at the following plane.
                if (bcm_done) begin
                    state_d = i_enable ? SHIFT : IDLE;
                    if (plane_q == plane_last) begin
                        plane_d = '0;
                        if (row_q == row_last) begin
                            row_d     = '0;
                            frame_end = 1'b1;
                        end else begin
                            row_d = row_q + row_width_p'(1);
                        end
                    end else begin
                        plane_d = plane_q + plane_w'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Phase 0 reads the top-half pixel, phase 1 the matching bottom-half pixel.
    always_comb begin
        rd_en_d = (state_d == SHIFT) && !phase_d[1];
        row_a   = addr_width_p'(row_d) + (phase_d[0] ? half_a : '0);
        addr_d  = row_a * hpix_a + addr_width_p'(col_d);
    end

    assign bot_p1 = i_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            col_q        <= '0;
            plane_q      <= '0;
            row_q        <= '0;
            o_rd_en      <= 1'b0;
            o_rd_addr    <= '0;
            O_CLK        <= 1'b0;
            STB          <= 1'b0;
            OE           <= 1'b1;
            o_row        <= '0;
            o_frame_done <= 1'b0;
            R1           <= 1'b0;
            G1           <= 1'b0;
            B1           <= 1'b0;
            R2           <= 1'b0;
            G2           <= 1'b0;
            B2           <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            col_q        <= col_d;
            plane_q      <= plane_d;
            row_q        <= row_d;
            o_rd_en      <= rd_en_d;
            if (rd_en_d) begin
                o_rd_addr <= addr_d;
            end
            O_CLK        <= (state_d == SHIFT) && (phase_d == phase_last_c);
            STB          <= (state_d == LATCH);
            OE           <= (state_d != DISPLAY);
            if (state_d == BLANK) begin
                o_row <= row_d;
            end
            o_frame_done <= frame_end;
            // Stage p1 -> colour pins: bottom pixel is on the bus during
            // phase 2; both halves are driven while O_CLK is high in phase 3.
            if ((state_q == SHIFT) && (phase_q == 2'd2)) begin
                R1 <= top_p0.r[plane_q];
                G1 <= top_p0.g[plane_q];
                B1 <= top_p0.b[plane_q];
                R2 <= bot_p1.r[plane_q];
                G2 <= bot_p1.g[plane_q];
                B2 <= bot_p1.b[plane_q];
            end
        end
    end

    // Stage p0: top-half pixel arrives during phase 1 and is held until phase 2.
    always_ff @(posedge clk) begin
        if ((state_q == SHIFT) && (phase_q == 2'd1)) begin
            top_p0 <= i_rd_data;
        end
    end

endmodule
